// File: rtl/rd_stream_pkg.sv
// rd_stream_pkg
//   Shared helpers for the read-domain prefetch stream:
//   - buf_depth_dflt : default local buffer depth for a given RAM latency
//   - ram_lat_legal  : RAM read latencies the stream supports (1 or 2)
//   - cnt_w          : width of a counter that must hold 0..n inclusive
//   - ptr_w          : width of a pointer indexing n entries (min 1 bit)
package rd_stream_pkg;

   // Latency + 2 entries covers the words in flight plus one word being
   // popped, which is what sustains one word per cycle.
   function automatic int buf_depth_dflt(input int ram_lat);
      return ram_lat + 2;
   endfunction

   function automatic bit ram_lat_legal(input int ram_lat);
      return (ram_lat == 1) || (ram_lat == 2);
   endfunction

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int ptr_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// rd_skid_buf
//   Circular register buffer holding prefetched read words.
//   Ports:
//     clk, aclr      clock, asynchronous active-low clear
//     wr_en, wr_data capture a word at the write pointer
//     rd_en          pop the head word (ignored while empty)
//     cnt            number of stored words, 0..DEPTH
//     head           word at the read pointer
module rd_skid_buf
   import rd_stream_pkg::*;
#(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 3,
   parameter int CW     = cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              aclr,
   input  logic              wr_en,
   input  logic [DWIDTH-1:0] wr_data,
   input  logic              rd_en,
   output logic [CW-1:0]     cnt,
   output logic [DWIDTH-1:0] head
);

   localparam int PW = ptr_w(DEPTH);

   logic [DEPTH-1:0][DWIDTH-1:0] mem;
   logic [PW-1:0]                wptr;
   logic [PW-1:0]                rptr;
   logic                         pop;

   // Explicit wrap so non-power-of-two depths stay in range.
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign pop  = rd_en & (cnt != '0);
   assign head = mem[rptr];

   // Entries are cleared too, so the head word reads 0 out of reset.
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         mem  <= '0;
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (wr_en) begin
            mem[wptr] <= wr_data;
            wptr      <= inc(wptr);
         end
         if (pop)
            rptr <= inc(rptr);
         case ({wr_en, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // The upstream credit rule must make this unreachable.
   ovf_chk: assert property (@(posedge clk) disable iff (!aclr)
      !(wr_en && (cnt == CW'(DEPTH)) && !pop));

endmodule

// File: rtl/rd_prefetch_stream.sv
// rd_prefetch_stream
//   Converts the FIFO request/empty read port into a show-ahead
//   valid/ready stream by prefetching into a small local buffer.
//   Ports:
//     rd_clk_i, aclr_i  read clock, asynchronous active-low reset
//     rd_empty_i        registered FIFO empty flag
//     rd_req_o          read request; every asserted cycle is a read
//     rd_q_i            RAM data, valid RAM_LAT cycles after a request
//     m_valid_o/m_ready_i/m_data_o  output stream
module rd_prefetch_stream
   import rd_stream_pkg::*;
#(
   parameter int DWIDTH    = 8,
   parameter int RAM_LAT   = 1,
   parameter int BUF_DEPTH = buf_depth_dflt(RAM_LAT)
) (
   input  logic              rd_clk_i,
   input  logic              aclr_i,
   input  logic              rd_empty_i,
   output logic              rd_req_o,
   input  logic [DWIDTH-1:0] rd_q_i,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic [DWIDTH-1:0] m_data_o
);

   localparam int CW = cnt_w(BUF_DEPTH);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

   if (!ram_lat_legal(RAM_LAT)) begin : g_bad_lat
      $error("rd_prefetch_stream: RAM_LAT must be 1 or 2");
   end

   logic [RAM_LAT-1:0] lat_sr;
   logic [RAM_LAT-1:0] lat_sr_nxt;
   logic [CW-1:0]      inflight_cnt;
   logic [CW-1:0]      buf_cnt;
   logic               req;
   logic               cap;
   logic               pop;

   // Credit check uses registered counts only, so m_ready_i never reaches
   // rd_req_o combinationally. Gating with aclr_i keeps the request low
   // for the whole reset even while the FIFO reports non-empty.
   assign req      = aclr_i & ~rd_empty_i
                   & (({1'b0, inflight_cnt} + {1'b0, buf_cnt}) < DEPTH_W);
   assign rd_req_o = req;

   // The request bit leaving the shift register marks the cycle in which
   // rd_q_i carries that request's word.
   assign cap = lat_sr[RAM_LAT-1];

   if (RAM_LAT == 1) begin : g_lat1
      assign lat_sr_nxt = req;
   end else begin : g_latn
      assign lat_sr_nxt = {lat_sr[RAM_LAT-2:0], req};
   end

   // inflight_cnt tracks the population count of lat_sr incrementally.
   always_ff @(posedge rd_clk_i or negedge aclr_i) begin
      if (!aclr_i) begin
         lat_sr       <= '0;
         inflight_cnt <= '0;
      end else begin
         lat_sr       <= lat_sr_nxt;
         inflight_cnt <= inflight_cnt + CW'(req) - CW'(cap);
      end
   end

   assign m_valid_o = (buf_cnt != '0);
   assign pop       = m_valid_o & m_ready_i;

   rd_skid_buf #(
      .DWIDTH (DWIDTH),
      .DEPTH  (BUF_DEPTH),
      .CW     (CW)
   ) u_buf (
      .clk     (rd_clk_i),
      .aclr    (aclr_i),
      .wr_en   (cap),
      .wr_data (rd_q_i),
      .rd_en   (pop),
      .cnt     (buf_cnt),
      .head    (m_data_o)
   );

endmodule
